// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int ADDR_W_DEF       = 10;
  localparam int DATA_W_DEF       = 32;
  localparam int LEN_W_DEF        = 4;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic {IDLE, DBG_BURST} arb_state_t;
  typedef enum logic [1:0] {NONE, CPU, DBG} owner_t;
endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority, locked debug bursts with a
// starvation bound, and flush-cancellable CPU read responses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LEN_W        = LEN_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_BF,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_flush,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [LEN_W-1:0]  dbg_len,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stall_cnt
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state, state_nxt;
  owner_t            owner;
  logic [SC_W-1:0]   starve;
  logic [LEN_W-1:0]  beat, len_q;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  logic              dbg_first;
  logic              dbg_force;

  // Grants are forced low during reset so every output reads 0 immediately.
  always_comb begin
    state_nxt = state;
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    dbg_done  = 1'b0;
    dbg_first = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dbg_force = dbg_req && (starve == SC_W'(STARVE_LIMIT));
    if (!rst_BF) begin
      case (state)
        IDLE: begin
          if (dbg_req && (dbg_force || !cpu_req)) begin
            dbg_gnt   = 1'b1;
            dbg_first = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            if (dbg_len == '0) dbg_done  = 1'b1;
            else               state_nxt = DBG_BURST;
          end else if (cpu_req) begin
            cpu_gnt   = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
          end
        end
        DBG_BURST: begin
          dbg_gnt   = 1'b1;
          mem_we    = we_q;
          mem_addr  = base_q + ADDR_W'(beat);
          mem_wdata = dbg_wdata;
          if (beat == len_q) begin
            dbg_done  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    mem_en = cpu_gnt | dbg_gnt;
  end

  always_ff @(posedge clk or posedge rst_BF) begin
    if (rst_BF) begin
      state     <= IDLE;
      owner     <= NONE;
      starve    <= '0;
      beat      <= '0;
      len_q     <= '0;
      base_q    <= '0;
      we_q      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (dbg_first) begin
        base_q <= dbg_addr;
        we_q   <= dbg_we;
        len_q  <= dbg_len;
      end
      if (dbg_done)                beat <= '0;
      else if (dbg_first)          beat <= LEN_W'(1);
      else if (state == DBG_BURST) beat <= beat + LEN_W'(1);

      if (dbg_gnt) starve <= '0;
      else if (state == IDLE && dbg_req && starve != SC_W'(STARVE_LIMIT))
        starve <= starve + SC_W'(1);

      // A read flushed in its grant cycle never claims the response slot.
      if (cpu_gnt && !cpu_we && !cpu_flush) owner <= CPU;
      else if (dbg_gnt && !mem_we)          owner <= DBG;
      else                                  owner <= NONE;

      if (cpu_req && !cpu_gnt && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign cpu_rvalid = (owner == CPU) && !cpu_flush;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rvalid = (owner == DBG);
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts each cycle's grants and
// read data; a negedge monitor pops and compares against the DUT.
module tb_dmem_arbiter;
  localparam int AW = 10, DW = 32, LW = 4, SL = 8, DEPTH = 1 << AW;

  logic clk = 1'b0, rst_BF;
  logic cpu_req, cpu_we, cpu_flush, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata, mem_wdata, mem_rdata;
  logic dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_done, mem_en, mem_we;
  logic [LW-1:0] dbg_len;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_BF(rst_BF),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_flush(cpu_flush), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_done(dbg_done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt));

  // 1-cycle synchronous RAM on the memory port
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  assign mem_rdata = ram_q;

  typedef struct {
    bit cg, dg, done, we, crv, drv;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [31:0] stall;
  } exp_t;

  exp_t ctl_q[$];
  logic [DW-1:0] crd_q[$], drd_q[$];
  int checks = 0, errors = 0;

  // reference model state
  logic [DW-1:0] gmem [DEPTH];
  int m_left, m_idx, m_base, m_starve;
  bit m_bwe, m_first, pc, pd;
  logic [DW-1:0] pcd, pdd;
  int unsigned m_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_idx = 0; m_base = 0; m_starve = 0; m_stall = 0;
    m_bwe = 0; m_first = 0; pc = 0; pd = 0;
  endtask

  // Predict this cycle from the current inputs, then advance the model one cycle.
  task automatic model_step();
    exp_t e;
    int a;
    e = '{default: 0};
    a = 0;
    m_first = 0;
    e.stall = m_stall;
    e.crv = pc && !cpu_flush;
    if (e.crv) crd_q.push_back(pcd);
    e.drv = pd;
    if (pd) drd_q.push_back(pdd);
    pc = 0; pd = 0;
    if (m_left > 0) begin
      e.dg = 1; a = (m_base + m_idx) % DEPTH; e.we = m_bwe;
      m_idx++; m_left--; e.done = (m_left == 0);
    end else if (dbg_req && (m_starve == SL || !cpu_req)) begin
      e.dg = 1; a = int'(dbg_addr); e.we = dbg_we; m_first = 1;
      m_bwe = dbg_we; m_base = int'(dbg_addr); m_idx = 1; m_left = int'(dbg_len);
      e.done = (dbg_len == 0);
    end else if (cpu_req) begin
      e.cg = 1; a = int'(cpu_addr); e.we = cpu_we;
    end
    if (e.dg) m_starve = 0;
    else if (dbg_req && m_starve < SL) m_starve++;
    if (cpu_req && !e.cg && m_stall != 32'hFFFF_FFFF) m_stall++;
    e.addr = AW'(a);
    e.wdata = e.dg ? dbg_wdata : cpu_wdata;
    if (e.cg || e.dg) begin
      if (e.we) gmem[a] = e.wdata;
      else if (e.cg) begin pc = !cpu_flush; pcd = gmem[a]; end
      else begin pd = 1; pdd = gmem[a]; end
    end
    ctl_q.push_back(e);
  endtask

  task automatic cyc(input bit cr, input bit cw, input int ca, input logic [DW-1:0] cd, input bit cf,
                     input bit dr, input bit dw, input int da, input int dl, input logic [DW-1:0] dd);
    @(posedge clk); #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = AW'(ca); cpu_wdata = cd; cpu_flush = cf;
    dbg_req = dr; dbg_we = dw; dbg_addr = AW'(da); dbg_len = LW'(dl); dbg_wdata = dd;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic zero_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_flush = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_len = '0; dbg_wdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_gnt"}, cpu_gnt, 0);
    chk({tag, "_dbg_gnt"}, dbg_gnt, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_dbg_done"}, dbg_done, 0);
    chk({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
    chk({tag, "_dbg_rvalid"}, dbg_rvalid, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (ctl_q.size() > 0) begin
      e = ctl_q.pop_front();
      chk("cpu_gnt", cpu_gnt, e.cg);
      chk("dbg_gnt", dbg_gnt, e.dg);
      chk("dbg_done", dbg_done, e.done);
      chk("mem_en", mem_en, e.cg | e.dg);
      if (e.cg | e.dg) begin
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", mem_we, e.we);
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
      chk("cpu_rvalid", cpu_rvalid, e.crv);
      chk("dbg_rvalid", dbg_rvalid, e.drv);
      chk("stall_cnt", stall_cnt, e.stall);
      if (cpu_rvalid) begin
        if (crd_q.size() == 0) chk("cpu_resp_expected", 1, 0);
        else chk("cpu_rdata", cpu_rdata, crd_q.pop_front());
      end
      if (dbg_rvalid) begin
        if (drd_q.size() == 0) chk("dbg_resp_expected", 1, 0);
        else chk("dbg_rdata", dbg_rdata, drd_q.pop_front());
      end
    end
  end

  initial begin
    bit dhold, dw_r;
    int da_r, dl_r;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = $urandom;
      gmem[i] = ram[i];
    end
    ram_q = '0;
    model_reset();
    zero_inputs();
    rst_BF = 1;
    cpu_req = 1; dbg_req = 1;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    zero_inputs();
    rst_BF = 0;

    // store then load at 370
    cyc(1, 1, 370, 32'd1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 370, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // debug read burst 368..378
    cyc(0, 0, 0, 0, 0, 1, 0, 368, 10, 0);
    idle(11);

    // starvation: debug forced on the 9th contended cycle
    for (int i = 0; i < 9; i++) cyc(1, 0, 10 + i, 0, 0, 1, 1, 5, 0, 32'hD00D_0005);
    for (int i = 0; i < 3; i++) cyc(1, 0, 20 + i, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // flush in response cycle, flush at grant, flushed store still written
    cyc(1, 0, 100, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 101, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    cyc(1, 1, 200, 32'hABCD_1234, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 200, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // wrapping burst with CPU locked out
    cyc(0, 0, 0, 0, 0, 1, 1, 1022, 3, $urandom);
    for (int i = 0; i < 4; i++) cyc(1, 0, 300, 0, 0, 0, 0, 0, 0, $urandom);
    cyc(0, 0, 0, 0, 0, 1, 0, 1022, 3, 0);
    idle(4);

    // reset during beat 2 of a burst
    cyc(0, 0, 0, 0, 0, 1, 0, 500, 7, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 500, 7, 0);
    @(posedge clk); #2;
    rst_BF = 1;
    #1 chk_all_zero("midburst_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    zero_inputs();
    model_reset();
    rst_BF = 0;
    cyc(0, 0, 0, 0, 0, 1, 0, 40, 2, 0);
    idle(4);

    // randomized traffic
    dhold = 0; dw_r = 0; da_r = 0; dl_r = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!dhold && $urandom_range(0, 5) == 0) begin
        dhold = 1;
        da_r = $urandom_range(0, DEPTH - 1);
        dl_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
        dw_r = $urandom_range(0, 1);
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 31), $urandom,
          $urandom_range(0, 9) == 0, dhold, dw_r, da_r, dl_r, $urandom);
      if (m_first) dhold = 0;
    end
    idle(20);
    @(negedge clk); #1;
    chk("cpu_resp_drained", crd_q.size(), 0);
    chk("dbg_resp_drained", drd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
